// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: state width and the
// elaboration-time KMP next-state function.
package seq_det_pkg;

  function automatic int clog2_state(input int width);
    return $clog2(width + 1);
  endfunction

  // Next state from "k bits of pattern matched" after receiving b. Pattern bit j
  // (j = 0 is the first bit received) lives at pattern[width-1-j]. From the full
  // match state the next state may be a full match again (self-overlapping patterns).
  function automatic int failure_next(input logic [15:0] pattern, input int width,
                                      input int k, input logic b);
    logic [16:0] s;
    int          res;
    logic        hit;
    res = 0;
    if (k < width && b == pattern[width-1-k]) return k + 1;
    s = '0;
    for (int j = 0; j < k; j++) s[j] = pattern[width-1-j];
    s[k] = b;
    for (int len = 1; len <= k && len <= width; len++) begin
      hit = 1'b1;
      for (int j = 0; j < len; j++)
        if (s[k+1-len+j] != pattern[width-1-j]) hit = 1'b0;
      if (hit) res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating up-counter: counts enabled cycles, sticks at all-ones.
module seq_det_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seq_detector_1011.sv
// Moore serial pattern detector with KMP transitions and a saturating match counter.
//   state     | meaning
//   0         | no prefix of the pattern matched (S0)
//   1..W-1    | that many leading pattern bits matched
//   W         | DETECT: full pattern just received, dout high
module seq_detector_1011
  import seq_det_pkg::*;
#(
  parameter int                 PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP   = 1'b1,
  parameter int                 CNT_W     = 8
) (
  input  logic                                din,
  input  logic                                clk,
  input  logic                                rst,
  output logic                                dout,
  output logic [CNT_W-1:0]                    match_cnt,
  output logic [clog2_state(PATTERN_W)-1:0]   state
);

  localparam int SW    = clog2_state(PATTERN_W);
  localparam int TBL_N = 2 ** (SW + 1);
  localparam logic [SW-1:0] S_DET = SW'(PATTERN_W);

  logic [SW-1:0] state_nxt;
  logic [SW-1:0] nxt_tbl [TBL_N];

  // Transition table indexed by {state, din}; unreachable encodings fall back to S0.
  for (genvar i = 0; i < TBL_N; i++) begin : g_tbl
    localparam int K    = i / 2;
    localparam int KEFF = (K > PATTERN_W || (K == PATTERN_W && !OVERLAP)) ? 0 : K;
    localparam int NXT  = (K > PATTERN_W) ? 0
                          : failure_next(16'(PATTERN), PATTERN_W, KEFF, (i % 2) == 1);
    assign nxt_tbl[i] = SW'(NXT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= '0;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = '0;
    state_nxt = nxt_tbl[{state, din}];
  end

  assign dout = (state == S_DET);

  seq_det_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (state_nxt == S_DET),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_1011.sv
// Directed bench for seq_detector_1011: default, non-overlap, 2-bit counter and "11" variants.
module tb_seq_detector_1011;

  logic clk = 1'b0;
  logic rst;
  logic din;

  logic       dout,     dout_no,  dout_sat, dout_11;
  logic [7:0] cnt,      cnt_no,   cnt_11;
  logic [1:0] cnt_sat;
  logic [2:0] st,       st_no,    st_sat;
  logic [1:0] st_11;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_1011 dut (
    .din(din), .clk(clk), .rst(rst), .dout(dout), .match_cnt(cnt), .state(st));

  seq_detector_1011 #(.OVERLAP(1'b0)) dut_no (
    .din(din), .clk(clk), .rst(rst), .dout(dout_no), .match_cnt(cnt_no), .state(st_no));

  seq_detector_1011 #(.CNT_W(2)) dut_sat (
    .din(din), .clk(clk), .rst(rst), .dout(dout_sat), .match_cnt(cnt_sat), .state(st_sat));

  seq_detector_1011 #(.PATTERN_W(2), .PATTERN(2'b11)) dut_11 (
    .din(din), .clk(clk), .rst(rst), .dout(dout_11), .match_cnt(cnt_11), .state(st_11));

  task automatic feed(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (st !== 3'd0) begin errors++; $display("FAIL reset_async_state: got %0d expected 0", st); end
    for (int i = 0; i < 2; i++) begin
      feed(i == 0);
      checks++;
      if (dout !== 1'b0 || cnt !== 8'd0 || st !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got dout=%b cnt=%0d state=%0d expected 0/0/0", i, dout, cnt, st);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      feed(1'b0);
      checks++;
      if (st !== 3'd0 || dout !== 1'b0) begin
        errors++; $display("FAIL reset_zeros[%0d]: got state=%0d dout=%b expected 0/0", i, st, dout);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] bits = 4'b1011;
    int exp_st[4] = '{1, 2, 3, 4};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      feed(bits[3-i]);
      checks++;
      if (st !== 3'(exp_st[i]) || dout !== (i == 3)) begin
        errors++;
        $display("FAIL basic[%0d]: got state=%0d dout=%b expected %0d/%b", i, st, dout, exp_st[i], i == 3);
      end
    end
    checks++;
    if (cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d expected 1", cnt); end
    feed(1'b0);
    checks++;
    if (st !== 3'd2 || dout !== 1'b0) begin
      errors++; $display("FAIL basic_after0: got state=%0d dout=%b expected 2/0", st, dout);
    end
    feed(1'b1);
    checks++;
    if (st !== 3'd3) begin errors++; $display("FAIL basic_after1: got state=%0d expected 3", st); end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp_ov = 7'b0001001;
    logic [6:0] exp_no = 7'b0001000;
    int exp_st[7] = '{1, 2, 3, 4, 2, 3, 4};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      feed(bits[6-i]);
      checks++;
      if (dout !== exp_ov[6-i] || st !== 3'(exp_st[i])) begin
        errors++;
        $display("FAIL overlap_on[%0d]: got dout=%b state=%0d expected %b/%0d", i, dout, st, exp_ov[6-i], exp_st[i]);
      end
      checks++;
      if (dout_no !== exp_no[6-i]) begin
        errors++; $display("FAIL overlap_off[%0d]: got dout=%b expected %b", i, dout_no, exp_no[6-i]);
      end
    end
    checks++;
    if (cnt !== 8'd2 || cnt_no !== 8'd1) begin
      errors++; $display("FAIL overlap_cnt: got %0d/%0d expected 2/1", cnt, cnt_no);
    end
  endtask

  task automatic test_near_miss();
    logic [4:0] a = 5'b11011;
    int sa[5] = '{1, 1, 2, 3, 4};
    logic [6:0] b = 7'b1001011;
    int sb[7] = '{1, 2, 0, 1, 2, 3, 4};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      feed(a[4-i]);
      checks++;
      if (st !== 3'(sa[i]) || dout !== (i == 4)) begin
        errors++;
        $display("FAIL near_a[%0d]: got state=%0d dout=%b expected %0d/%b", i, st, dout, sa[i], i == 4);
      end
    end
    do_reset();
    for (int i = 0; i < 7; i++) begin
      feed(b[6-i]);
      checks++;
      if (st !== 3'(sb[i]) || dout !== (i == 6)) begin
        errors++;
        $display("FAIL near_b[%0d]: got state=%0d dout=%b expected %0d/%b", i, st, dout, sb[i], i == 6);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    feed(1'b1); feed(1'b0); feed(1'b1);
    #3 rst = 1'b0;
    #1;
    checks++;
    if (st !== 3'd0 || dout !== 1'b0 || cnt !== 8'd0) begin
      errors++; $display("FAIL midrst_async: got state=%0d dout=%b cnt=%0d expected 0/0/0", st, dout, cnt);
    end
    #1 rst = 1'b1;
    feed(1'b1);
    checks++;
    if (st !== 3'd1 || dout !== 1'b0 || cnt !== 8'd0) begin
      errors++; $display("FAIL midrst_after: got state=%0d dout=%b cnt=%0d expected 1/0/0", st, dout, cnt);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] bits = 4'b1011;
    int pulses = 0;
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 4; i++) begin
        feed(bits[3-i]);
        if (dout_sat === 1'b1) pulses++;
      end
      checks++;
      if (cnt_sat !== 2'(exp_cnt[g])) begin
        errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", g, cnt_sat, exp_cnt[g]);
      end
    end
    checks++;
    if (pulses != 5) begin errors++; $display("FAIL sat_pulses: got %0d expected 5", pulses); end
    checks++;
    if (cnt !== 8'd5) begin errors++; $display("FAIL sat_wide_cnt: got %0d expected 5", cnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bits = 4'b1110;
    int exp_st[4] = '{1, 2, 2, 0};
    logic [3:0] exp_d = 4'b0110;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      feed(bits[3-i]);
      checks++;
      if (st_11 !== 2'(exp_st[i]) || dout_11 !== exp_d[3-i]) begin
        errors++;
        $display("FAIL b2b[%0d]: got state=%0d dout=%b expected %0d/%b", i, st_11, dout_11, exp_st[i], exp_d[3-i]);
      end
    end
    checks++;
    if (cnt_11 !== 8'd2) begin errors++; $display("FAIL b2b_cnt: got %0d expected 2", cnt_11); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_near_miss();
    test_mid_reset();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
